fp_unpack: RTL and testbench
============================

FP_UNPACK -- requirements
Module: fp_unpack

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width; FRAC_W, default 23, fraction field width; W = 1+EXP_W+FRAC_W (32 at defaults).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair a/b valid.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 a, b  input  W  packed operands: [W-1] sign, [W-2:FRAC_W] exponent, [FRAC_W-1:0] fraction.
REQ-007 out_valid  output  1  unpacked pair valid.
REQ-008 out_ready  input  1  consumer accepts the pair this cycle.
REQ-009 sign_a, sign_b  output  1  operand signs.
REQ-010 exponent_a, exponent_b  output  EXP_W  effective biased exponents.
REQ-011 mantissa_a, mantissa_b  output  FRAC_W+1  fraction with hidden bit at MSB.
REQ-012 class_a, class_b  output  4  {nan, inf, zero, denorm} one-hot or all-zero (normal).

Function
REQ-013 Input transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer occurs with out_valid=1 and out_ready=1.
REQ-014 Latency: an accepted pair appears on the outputs with out_valid=1 on the cycle after acceptance when the buffer was empty.
REQ-015 Storage is a 2-entry skid buffer (main output register plus skid register); states EMPTY, ONE, FULL.
REQ-016 EMPTY: accept -> ONE. ONE: accept and no output transfer -> FULL (pair to skid); output transfer and no accept -> EMPTY; both -> ONE (new pair to main). FULL: output transfer -> ONE (skid moves to main); accept is impossible.
REQ-017 in_ready SHALL be a registered signal, 0 exactly in FULL, 1 otherwise; it never depends combinationally on out_ready.
REQ-018 While out_valid=1 and out_ready=0, all data outputs hold stable.
REQ-019 Pair order is preserved; no pair is dropped or duplicated.
REQ-020 mantissa = {exponent field != 0, fraction}.
REQ-021 exponent output = raw exponent field, except 1 when the field is 0 and fraction != 0 (denormal).
REQ-022 Classification: zero = exp 0, frac 0; denorm = exp 0, frac != 0; inf = exp all-ones, frac 0; nan = exp all-ones, frac != 0; otherwise 4'b0000.
REQ-023 Unpacking and classification are computed on the input side and stored with the pair; outputs are driven directly from registers.

Reset
REQ-024 Reset low SHALL asynchronously force the EMPTY state, out_valid=0, in_ready=1, and every data and class output plus skid contents to 0.
REQ-025 A reset asserted mid-operation discards all buffered pairs; the first accept after release behaves as from EMPTY.

Configuration
REQ-026 Macro FP_UNPACK_CLASS_EN: when defined, class_a and class_b are computed per REQ-022 and registered.
REQ-027 When FP_UNPACK_CLASS_EN is undefined, class_a and class_b are constant 0 and no classification storage exists; all other behaviour is unchanged.

Verification
REQ-028 Defaults, out_ready=1, a=32'h3F800000 and b=32'hC0000000 for one cycle -> next cycle out_valid=1, sign_a=0, exponent_a=8'h7F, mantissa_a=24'h800000, sign_b=1, exponent_b=8'h80, class 0.
REQ-029 a=32'h00000001, b=32'h7FC00000 -> exponent_a=1, mantissa_a=24'h000001, class_a=denorm; exponent_b=8'hFF, class_b=nan (with FP_UNPACK_CLASS_EN); class outputs 0 without the macro.
REQ-030 out_ready=0, three back-to-back pairs P0,P1,P2 offered -> P0 and P1 accepted, in_ready=0 from the cycle after P1, P2 held; outputs stay at P0; then out_ready=1 -> P0, P1, P2 delivered in order, no gaps once streaming.
REQ-031 State ONE with in_valid=1 and out_ready=1 on the same edge -> state remains ONE, new pair on outputs, in_ready stays 1.
REQ-032 State FULL, reset pulsed low for less than one clock period -> out_valid=0 and in_ready=1 immediately, all outputs 0; the next accepted pair appears after one cycle.
REQ-033 Parameters EXP_W=5, FRAC_W=10, a=16'h7C00, b=16'h0000 -> class_a=inf, exponent_a=5'h1F, mantissa_a=11'h400; class_b=zero, mantissa_b=0.

Source files
------------

// File: rtl/fp_unpack.sv
// Two-entry skid buffer that unpacks a pair of IEEE-style operands into sign, effective exponent,
// hidden-bit mantissa and (optional, macro FP_UNPACK_CLASS_EN) a {nan, inf, zero, denorm} class.
module fp_unpack #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   localparam int W     = 1 + EXP_W + FRAC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      a,
   input  logic [W-1:0]      b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sign_a,
   output logic              sign_b,
   output logic [EXP_W-1:0]  exponent_a,
   output logic [EXP_W-1:0]  exponent_b,
   output logic [FRAC_W:0]   mantissa_a,
   output logic [FRAC_W:0]   mantissa_b,
   output logic [3:0]        class_a,
   output logic [3:0]        class_b,
   output logic [1:0]        o_dbg_state
);

   // Handshake: a pair moves on a rising edge when valid and ready are both 1 on that side.
   // in_ready is a flop and is low only while both entries are occupied.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam int OP_W = 1 + EXP_W + FRAC_W + 1;

   function automatic logic [OP_W-1:0] unpack_op(input logic [W-1:0] x);
      logic [EXP_W-1:0]  e;
      logic [FRAC_W-1:0] f;
      logic [EXP_W-1:0]  e_eff;
      e     = x[W-2:FRAC_W];
      f     = x[FRAC_W-1:0];
      // Denormals share the scale of the smallest normal exponent.
      e_eff = (e == '0 && f != '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : e;
      return {x[W-1], e_eff, (e != '0), f};
   endfunction

   logic [1:0]        r_state;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [2*OP_W-1:0] r_main;
   logic [2*OP_W-1:0] r_skid;

   logic [1:0]        w_state_nxt;
   logic              w_accept;
   logic              w_deq;
   logic              w_ld_main_in;
   logic              w_ld_skid;
   logic              w_ld_main_skid;
   logic [2*OP_W-1:0] w_in_data;

   assign w_accept  = in_valid & r_in_ready;
   assign w_deq     = r_out_valid & out_ready;
   assign w_in_data = {unpack_op(a), unpack_op(b)};

   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_skid      = 1'b0;
      w_ld_main_skid = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt  = ST_ONE;
               w_ld_main_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_accept && w_deq) begin
               w_ld_main_in = 1'b1;
            end else if (w_accept) begin
               w_state_nxt = ST_FULL;
               w_ld_skid   = 1'b1;
            end else if (w_deq) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_deq) begin
               w_state_nxt    = ST_ONE;
               w_ld_main_skid = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_main      <= '0;
         r_skid      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != ST_FULL);
         r_out_valid <= (w_state_nxt != ST_EMPTY);
         if (w_ld_main_in)   r_main <= w_in_data;
         if (w_ld_main_skid) r_main <= r_skid;
         if (w_ld_skid)      r_skid <= w_in_data;
      end
   end

`ifdef FP_UNPACK_CLASS_EN
   function automatic logic [3:0] classify(input logic [W-1:0] x);
      logic e_zero;
      logic e_ones;
      logic f_zero;
      e_zero = (x[W-2:FRAC_W] == '0);
      e_ones = &x[W-2:FRAC_W];
      f_zero = (x[FRAC_W-1:0] == '0);
      return {e_ones & ~f_zero, e_ones & f_zero, e_zero & f_zero, e_zero & ~f_zero};
   endfunction

   logic [7:0] r_main_cls;
   logic [7:0] r_skid_cls;
   logic [7:0] w_in_cls;

   assign w_in_cls = {classify(a), classify(b)};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_main_cls <= '0;
         r_skid_cls <= '0;
      end else begin
         if (w_ld_main_in)   r_main_cls <= w_in_cls;
         if (w_ld_main_skid) r_main_cls <= r_skid_cls;
         if (w_ld_skid)      r_skid_cls <= w_in_cls;
      end
   end

   assign {class_a, class_b} = r_main_cls;
`else
   assign class_a = 4'b0000;
   assign class_b = 4'b0000;
`endif

   assign {sign_a, exponent_a, mantissa_a, sign_b, exponent_b, mantissa_b} = r_main;
   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fp_unpack.sv
// Bench for fp_unpack: directed handshake scenarios plus randomized traffic checked by a
// queue-based scoreboard against an arithmetic reference model.
module tb_fp_unpack;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic        sign_a, sign_b;
   logic [7:0]  exponent_a, exponent_b;
   logic [23:0] mantissa_a, mantissa_b;
   logic [3:0]  class_a, class_b;
   logic [1:0]  o_dbg_state;

   logic        in_valid_h;
   logic        in_ready_h;
   logic [15:0] a_h;
   logic [15:0] b_h;
   logic        out_valid_h;
   logic        out_ready_h;
   logic        sign_a_h, sign_b_h;
   logic [4:0]  exponent_a_h, exponent_b_h;
   logic [10:0] mantissa_a_h, mantissa_b_h;
   logic [3:0]  class_a_h, class_b_h;
   logic [1:0]  o_dbg_state_h;

   int checks = 0;
   int errors = 0;
   logic [73:0] exp_q[$];
   logic        rand_done;

`ifdef FP_UNPACK_CLASS_EN
   localparam logic [3:0] CLS_NAN = 4'b1000, CLS_INF = 4'b0100, CLS_ZERO = 4'b0010, CLS_DEN = 4'b0001;
`else
   localparam logic [3:0] CLS_NAN = 4'b0000, CLS_INF = 4'b0000, CLS_ZERO = 4'b0000, CLS_DEN = 4'b0000;
`endif

   fp_unpack u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .sign_a(sign_a), .sign_b(sign_b),
      .exponent_a(exponent_a), .exponent_b(exponent_b), .mantissa_a(mantissa_a),
      .mantissa_b(mantissa_b), .class_a(class_a), .class_b(class_b), .o_dbg_state(o_dbg_state)
   );

   fp_unpack #(.EXP_W(5), .FRAC_W(10)) u_dut_h (
      .clk(clk), .reset(reset), .in_valid(in_valid_h), .in_ready(in_ready_h), .a(a_h), .b(b_h),
      .out_valid(out_valid_h), .out_ready(out_ready_h), .sign_a(sign_a_h), .sign_b(sign_b_h),
      .exponent_a(exponent_a_h), .exponent_b(exponent_b_h), .mantissa_a(mantissa_a_h),
      .mantissa_b(mantissa_b_h), .class_a(class_a_h), .class_b(class_b_h), .o_dbg_state(o_dbg_state_h)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: sign, effective exponent, hidden-bit mantissa, class
   function automatic logic [36:0] ref_op(input logic [31:0] x);
      int unsigned e, f;
      logic [7:0]  ee;
      logic [23:0] m;
      logic [3:0]  c;
      e  = (x >> 23) & 32'd255;
      f  = x & 32'h007F_FFFF;
      ee = (e == 0 && f != 0) ? 8'd1 : 8'(e);
      m  = (e != 0) ? 24'(f + 32'h0080_0000) : 24'(f);
      if (e == 255)    c = (f != 0) ? CLS_NAN : CLS_INF;
      else if (e == 0) c = (f != 0) ? CLS_DEN : CLS_ZERO;
      else             c = 4'b0000;
      return {x[31], ee, m, c};
   endfunction

   function automatic logic [73:0] got_vec();
      return {sign_a, exponent_a, mantissa_a, class_a, sign_b, exponent_b, mantissa_b, class_b};
   endfunction

   task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Driver: called at posedge+1; the pair is taken on the first edge that sees in_ready=1
   task automatic send(input logic [31:0] va, input logic [31:0] vb);
      int n;
      in_valid = 1'b1;
      a = va;
      b = vb;
      n = 0;
      while (!in_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
      end else begin
         exp_q.push_back({ref_op(va), ref_op(vb)});
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
   endtask

   function automatic logic [31:0] rand_op();
      logic [7:0]  e;
      logic [22:0] f;
      case ($urandom_range(0, 4))
         0:       e = 8'h00;
         1:       e = 8'hFF;
         default: e = 8'($urandom_range(0, 255));
      endcase
      f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
      return {1'($urandom_range(0, 1)), e, f};
   endfunction

   // Monitor: sample between edges; pop on a transfer, check hold during a stall
   always @(negedge clk) begin
      if (reset === 1'b1 && out_valid === 1'b1) begin
         if (out_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_output", got_vec(), 0);
            else                   chk("pair_data", got_vec(), exp_q.pop_front());
         end else if (exp_q.size() != 0) begin
            chk("stall_hold", got_vec(), exp_q[0]);
         end
      end
   end

   initial begin
      rand_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rand_done) break;
      end
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      in_valid_h = 1'b0; a_h = '0; b_h = '0; out_ready_h = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_data", got_vec(), 0);
      chk("reset_state", o_dbg_state, 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      // Basic unpack and one-cycle latency
      out_ready = 1'b1;
      send(32'h3F80_0000, 32'hC000_0000);
      chk("latency_out_valid", out_valid, 1);
      chk("basic_fields", {sign_a, exponent_a, mantissa_a, sign_b, exponent_b},
          {1'b0, 8'h7F, 24'h80_0000, 1'b1, 8'h80});
      drain();
      send(32'h0000_0001, 32'h7FC0_0000);
      chk("denorm_nan_class", {exponent_a, mantissa_a, class_a, exponent_b, class_b},
          {8'h01, 24'h00_0001, CLS_DEN, 8'hFF, CLS_NAN});
      drain();

      // Back-pressure: fill both entries, third pair must wait
      out_ready = 1'b0;
      send(32'h3F80_0000, 32'h4000_0000);
      send(32'h4040_0000, 32'h4080_0000);
      chk("full_in_ready", in_ready, 0);
      chk("full_state", o_dbg_state, 2);
      fork
         send(32'h40A0_0000, 32'h40C0_0000);
      join_none
      repeat (3) @(posedge clk);
      #1;
      chk("full_held_in_ready", in_ready, 0);
      chk("full_held_out_valid", out_valid, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stream_no_gap", out_valid, 1);
      end
      drain();

      // Simultaneous accept and dequeue while holding one pair
      send(32'h4110_0000, 32'h4120_0000);
      send(32'h4130_0000, 32'h4140_0000);
      chk("one_both_state", o_dbg_state, 1);
      chk("one_both_in_ready", in_ready, 1);
      drain();

      // Randomized traffic with random back-pressure
      fork
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join_none
      for (int i = 0; i < 150; i++) begin
         send(rand_op(), rand_op());
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      rand_done = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b1;
      drain();

      // Short reset pulse while full
      out_ready = 1'b0;
      send(32'h3F80_0000, 32'hBF80_0000);
      send(32'h4000_0000, 32'hC000_0000);
      chk("pre_reset_full", o_dbg_state, 2);
      #1 reset = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_in_ready", in_ready, 1);
      chk("async_data", got_vec(), 0);
      chk("async_state", o_dbg_state, 0);
      exp_q.delete();
      #1 reset = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(32'h4248_0000, 32'h0000_0000);
      chk("post_reset_latency", out_valid, 1);
      drain();

      // Half-precision geometry
      in_valid_h = 1'b1;
      a_h = 16'h7C00;
      b_h = 16'h0000;
      @(posedge clk); #1;
      in_valid_h = 1'b0;
      chk("half_out_valid", out_valid_h, 1);
      chk("half_in_ready", in_ready_h, 1);
      chk("half_fields",
          {sign_a_h, exponent_a_h, mantissa_a_h, class_a_h, sign_b_h, exponent_b_h, mantissa_b_h, class_b_h},
          {1'b0, 5'h1F, 11'h400, CLS_INF, 1'b0, 5'h00, 11'h000, CLS_ZERO});
      chk("half_state", o_dbg_state_h, 1);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
